// File: rtl/psx_pixel_fifo.sv
// rtl/psx_pixel_fifo.sv - PSX BGR555 to RGB888 pixel FIFO with first-word fall-through output
// Converts on push, stores 24-bit pixels, and counts starved output cycles once traffic has begun.
module psx_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [14:0]   pix_in,
  input  logic          pix_in_valid,
  output logic          pix_in_rdy,
  output logic [23:0]   video_out,
  output logic          video_valid,
  input  logic          video_rdy,
  output logic [CW-1:0] level,
  output logic [15:0]   underrun_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          started;
  logic          push;
  logic          pop;
  logic [23:0]   pix_rgb;

  // Replicating the top bits keeps full-scale 0x1F mapped to 0xFF.
  function automatic logic [7:0] expand(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  assign pix_rgb     = {expand(pix_in[4:0]), expand(pix_in[9:5]), expand(pix_in[14:10])};
  assign pix_in_rdy  = !rst && (level < CW'(DEPTH));
  assign video_valid = !rst && (level != '0);
  assign video_out   = video_valid ? mem[rd_ptr] : 24'h000000;
  assign push        = pix_in_valid && pix_in_rdy;
  assign pop         = video_valid && video_rdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pix_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      started      <= 1'b0;
      underrun_cnt <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        started <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
      if (started && video_rdy && !video_valid && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_psx_pixel_fifo.sv
// tb/tb_psx_pixel_fifo.sv - directed and scoreboard bench for psx_pixel_fifo
module tb_psx_pixel_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] pix_in;
  logic        pix_in_valid;
  logic        pix_in_rdy;
  logic [23:0] video_out;
  logic        video_valid;
  logic        video_rdy;
  logic [4:0]  level;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int errors = 0;
  int acc;
  logic [14:0] fp [20];
  logic [23:0] q [$];
  logic        m_push;
  logic        m_pop;
  int          push_pct;
  int          pop_pct;
  int          max_lvl;
  int          zero_hits;

  psx_pixel_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_in_rdy   (pix_in_rdy),
    .video_out    (video_out),
    .video_valid  (video_valid),
    .video_rdy    (video_rdy),
    .level        (level),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] cv(input logic [14:0] p);
    return {p[4:0], p[4:2], p[9:5], p[9:7], p[14:10], p[14:12]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pix_in = 15'h7FFF; pix_in_valid = 1'b1; video_rdy = 1'b1;
    cyc(); cyc();
    chk("rst_rdy", pix_in_rdy, 0);
    chk("rst_valid", video_valid, 0);
    chk("rst_out", video_out, 0);
    rst = 1'b0; pix_in_valid = 1'b0; video_rdy = 1'b0;
    #1;
    chk("post_rst_level", level, 0);
    chk("post_rst_rdy", pix_in_rdy, 1);
    chk("post_rst_cnt", underrun_cnt, 0);
    chk("post_rst_valid", video_valid, 0);

    // single pixel, no same-cycle bypass
    pix_in = 15'h7FFF; pix_in_valid = 1'b1; video_rdy = 1'b1;
    #1;
    chk("single_no_bypass", video_valid, 0);
    chk("single_no_bypass_out", video_out, 0);
    cyc();
    pix_in_valid = 1'b0;
    #1;
    chk("single_out", video_out, 24'hFFFFFF);
    chk("single_valid", video_valid, 1);
    chk("single_level1", level, 1);
    cyc();
    video_rdy = 1'b0;
    #1;
    chk("single_level0", level, 0);
    chk("single_empty_out", video_out, 0);

    // channel conversion
    for (int i = 0; i < 3; i++) begin
      pix_in = (i == 0) ? 15'h0010 : (i == 1) ? 15'h0200 : 15'h4000;
      pix_in_valid = 1'b1;
      cyc();
    end
    pix_in_valid = 1'b0; video_rdy = 1'b1;
    #1; chk("conv_r", video_out, 24'h840000); cyc();
    #1; chk("conv_g", video_out, 24'h008400); cyc();
    #1; chk("conv_b", video_out, 24'h000084); cyc();
    video_rdy = 1'b0;
    #1;
    chk("conv_empty", level, 0);

    // fill beyond capacity
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      fp[i] = 15'(i * 1057 + 3);
      pix_in = fp[i]; pix_in_valid = 1'b1;
      #1;
      if (pix_in_rdy) acc++;
      cyc();
    end
    pix_in_valid = 1'b0;
    #1;
    chk("fill_accepted", acc, 16);
    chk("fill_level", level, 16);
    chk("fill_rdy", pix_in_rdy, 0);
    chk("fill_head", video_out, cv(fp[0]));

    // pop while full, then simultaneous push and pop
    pix_in = 15'h1234; pix_in_valid = 1'b1; video_rdy = 1'b1;
    #1;
    chk("full_rdy_low", pix_in_rdy, 0);
    cyc();
    pix_in = 15'h2345;
    #1;
    chk("full_pop_level", level, 15);
    chk("full_pop_rdy", pix_in_rdy, 1);
    chk("full_pop_head", video_out, cv(fp[1]));
    cyc();
    pix_in_valid = 1'b0; video_rdy = 1'b0;
    #1;
    chk("pushpop_level", level, 15);
    chk("pushpop_head", video_out, cv(fp[2]));

    video_rdy = 1'b1;
    for (int i = 2; i < 16; i++) begin
      #1;
      chk("drain_order", video_out, cv(fp[i]));
      cyc();
    end
    #1;
    chk("drain_last", video_out, cv(15'h2345));
    cyc();
    cyc(); cyc(); cyc();
    chk("starve_cnt3", underrun_cnt, 3);
    chk("drain_level", level, 0);
    video_rdy = 1'b0;

    // reset mid-stream
    for (int i = 0; i < 8; i++) begin
      pix_in = 15'(i * 77 + 5); pix_in_valid = 1'b1;
      cyc();
    end
    pix_in_valid = 1'b0;
    #1;
    chk("mid_level8", level, 8);
    rst = 1'b1; pix_in_valid = 1'b1; video_rdy = 1'b1;
    #1;
    chk("mid_rst_rdy", pix_in_rdy, 0);
    chk("mid_rst_valid", video_valid, 0);
    chk("mid_rst_out", video_out, 0);
    cyc();
    rst = 1'b0; pix_in_valid = 1'b0; video_rdy = 1'b0;
    #1;
    chk("mid_level0", level, 0);
    chk("mid_rdy", pix_in_rdy, 1);
    chk("mid_valid", video_valid, 0);
    chk("mid_cnt", underrun_cnt, 0);
    pix_in = 15'h5A5A; pix_in_valid = 1'b1;
    cyc();
    pix_in_valid = 1'b0; video_rdy = 1'b1;
    #1;
    chk("mid_sole_out", video_out, cv(15'h5A5A));
    chk("mid_sole_level", level, 1);
    cyc();
    video_rdy = 1'b0;
    #1;
    chk("mid_sole_gone", video_valid, 0);

    // underrun counting and saturation
    rst = 1'b1;
    cyc();
    rst = 1'b0; video_rdy = 1'b1;
    cyc(); cyc(); cyc();
    chk("unr_prestart", underrun_cnt, 0);
    pix_in = 15'h0001; pix_in_valid = 1'b1;
    cyc();
    pix_in_valid = 1'b0;
    repeat (10) cyc();
    chk("unr_nine", underrun_cnt, 9);
    force dut.underrun_cnt = 16'hFFFF;
    cyc();
    release dut.underrun_cnt;
    repeat (3) cyc();
    chk("unr_saturate", underrun_cnt, 16'hFFFF);
    video_rdy = 1'b0;

    // randomized traffic against a queue model
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    max_lvl = 0; zero_hits = 0;
    for (int c = 0; c < 10000; c++) begin
      if ((c / 400) % 2 == 0) begin push_pct = 80; pop_pct = 30; end
      else begin push_pct = 30; pop_pct = 80; end
      pix_in       = 15'($urandom);
      pix_in_valid = ($urandom_range(99) < push_pct);
      video_rdy    = ($urandom_range(99) < pop_pct);
      #1;
      chk("rnd_level", level, q.size());
      chk("rnd_rdy", pix_in_rdy, (q.size() < 16));
      chk("rnd_valid", video_valid, (q.size() > 0));
      if (q.size() > 0) chk("rnd_out", video_out, q[0]);
      else chk("rnd_out_zero", video_out, 0);
      m_push = pix_in_valid && (q.size() < 16);
      m_pop  = video_rdy && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(cv(pix_in));
      if (q.size() > max_lvl) max_lvl = q.size();
      if (q.size() == 0) zero_hits++;
      cyc();
    end
    chk("rnd_reached_full", max_lvl, 16);
    chk("rnd_reached_empty", (zero_hits > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
